alu_arbiter: RTL and testbench

- Shares the single combinational 32-bit alu datapath (a, b, 17-bit op → alu_out) between NUM_REQ requesters, e.g. the PID, PWM and encoder units of the motor-controller accelerator.
- Round-robin arbitration, valid/ready request handshake, registered ALU operands, registered result, per-requester response handshake.
- Sits between the requester units and one alu instance; the alu is instantiated outside this block.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_arbiter_rr.sv | 50 +++++
 rtl/alu_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sharing logic: default operand/op widths,
// RISC-V style op field encodings, the arbiter FSM state type and a helper
// for building a packed 17-bit op {funct7, funct3, opcode}.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 17;

  // opcode field
  localparam logic [6:0] OPC_OP = 7'b0110011;

  // funct3 field
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // funct7 field; ALT selects SUB / SRA
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [OP_W_DEF-1:0] make_op(input logic [6:0] f7,
                                                  input logic [2:0] f3,
                                                  input logic [6:0] opc);
    return {f7, f3, opc};
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. The search starts one position
// after last_grant and wraps, so the most recently served requester has the
// lowest priority.
// Ports:
//   req        in  NUM_REQ  request bits
//   last_grant in  IDX_W    index served most recently
//   grant      out NUM_REQ  one-hot grant (all zero when no request)
//   grant_idx  out IDX_W    index of the granted requester
//   any_req    out 1        at least one request bit set
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  // cand_idx[k] is the requester examined at priority position k
  logic [IDX_W-1:0] cand_idx [NUM_REQ];
  logic             found;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand_idx[gi] =
        IDX_W'((32'(last_grant) + 32'(gi) + 32'd1) % 32'(NUM_REQ));
    end
  endgenerate

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[cand_idx[k]]) begin
        found     = 1'b1;
        grant_idx = cand_idx[k];
      end
    end
    grant = found ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  assign any_req = |req;

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one external combinational ALU between NUM_REQ requesters.
// IDLE accepts one request (round robin), EXEC gives the ALU a full cycle on
// the registered operands, RESP presents the result to the granted requester
// until it accepts.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester request handshake (ready one-hot)
//   req_a/req_b/req_op       packed per-requester payload, slot i at [i*W +: W]
//   rsp_valid/rsp_ready      per-requester response handshake (valid one-hot)
//   rsp_data                 shared registered result bus
//   alu_a/alu_b/alu_op       registered operands to the ALU
//   alu_out                  ALU result
//   busy                     high whenever not IDLE
// -----------------------------------------------------------------------------
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int OP_W    = OP_W_DEF,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_op,
  input  logic [DATA_W-1:0]         alu_out,
  output logic                      busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_t               state_reg;
  logic [IDX_W-1:0]     last_grant_reg;
  logic [IDX_W-1:0]     grant_idx_reg;
  logic [NUM_REQ-1:0]   rsp_valid_reg;
  logic                 busy_reg;
  logic [DATA_W-1:0]    rsp_data_reg;
  logic [DATA_W-1:0]    alu_a_reg;
  logic [DATA_W-1:0]    alu_b_reg;
  logic [OP_W-1:0]      alu_op_reg;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;

  // Unpacked views of the packed request payloads
  logic [DATA_W-1:0]    a_slice  [NUM_REQ];
  logic [DATA_W-1:0]    b_slice  [NUM_REQ];
  logic [OP_W-1:0]      op_slice [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign a_slice[gi]  = req_a[gi*DATA_W +: DATA_W];
      assign b_slice[gi]  = req_b[gi*DATA_W +: DATA_W];
      assign op_slice[gi] = req_op[gi*OP_W +: OP_W];
    end
  endgenerate

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any_req    (arb_any)
  );

  // Accept strobe is combinational in IDLE; masked during reset so a request
  // is never shown as accepted on an edge that will not capture it.
  assign req_ready = (state_reg == IDLE && !rst) ? arb_grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= LAST_IDX;
      grant_idx_reg  <= '0;
      rsp_valid_reg  <= '0;
      busy_reg       <= 1'b0;
      rsp_data_reg   <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_op_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arb_any) begin
            alu_a_reg     <= a_slice[arb_idx];
            alu_b_reg     <= b_slice[arb_idx];
            alu_op_reg    <= op_slice[arb_idx];
            grant_idx_reg <= arb_idx;
            busy_reg      <= 1'b1;
            state_reg     <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_reg  <= alu_out;
          rsp_valid_reg <= NUM_REQ'(1) << grant_idx_reg;
          state_reg     <= RESP;
        end
        RESP: begin
          // Only the granted requester's ready bit matters
          if (rsp_ready[grant_idx_reg]) begin
            last_grant_reg <= grant_idx_reg;
            rsp_valid_reg  <= '0;
            busy_reg       <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: begin
          rsp_valid_reg <= '0;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign busy      = busy_reg;
  assign rsp_data  = rsp_data_reg;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_op    = alu_op_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Bench for alu_arbiter with a behavioural ALU attached. Accepted requests
// push their expected result (computed from the bench's own payload) into a
// queue; completed responses pop and compare.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int OW = 17;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_a = '0;
  logic [N*DW-1:0]   req_b = '0;
  logic [N*OW-1:0]   req_op = '0;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready = '1;
  logic [DW-1:0]     rsp_data;
  logic [DW-1:0]     alu_a;
  logic [DW-1:0]     alu_b;
  logic [OW-1:0]     alu_op;
  logic [DW-1:0]     alu_out;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .busy      (busy)
  );

  // Behavioural RV32 ALU (the block that sits outside the arbiter)
  function automatic logic [31:0] alu_model(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [16:0] op);
    logic [2:0] f3;
    logic       alt;
    f3  = op[9:7];
    alt = op[15];
    case (f3)
      F3_ADD_SUB: return alt ? a - b : a + b;
      F3_SLL:     return a << b[4:0];
      F3_SLT:     return {31'd0, $signed(a) < $signed(b)};
      F3_SLTU:    return {31'd0, a < b};
      F3_XOR:     return a ^ b;
      F3_SRL_SRA: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      F3_OR:      return a | b;
      default:    return a & b;
    endcase
  endfunction

  assign alu_out = alu_model(alu_a, alu_b, alu_op);

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      sb_q.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] === 1'b1 && req_valid[i] === 1'b1) begin
          exp_t e;
          e.idx  = i;
          e.data = alu_model(req_a[i*DW +: DW], req_b[i*DW +: DW],
                             req_op[i*OW +: OW]);
          sb_q.push_back(e);
          $display("accept req%0d a=%h b=%h op=%h", i, req_a[i*DW +: DW],
                   req_b[i*DW +: DW], req_op[i*OW +: OW]);
        end
      end
      if ((rsp_valid & rsp_ready) != '0) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 64'(rsp_valid), 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          $display("response rsp_valid=%b data=%h", rsp_valid, rsp_data);
          check("sb_valid", 64'(rsp_valid), 64'(4'b0001 << e.idx));
          check("sb_data", 64'(rsp_data), 64'(e.data));
        end
      end
    end
  end

  task automatic set_req(input int idx, input logic [31:0] a,
                         input logic [31:0] b, input logic [16:0] op);
    req_a[idx*DW +: DW]  = a;
    req_b[idx*DW +: DW]  = b;
    req_op[idx*OW +: OW] = op;
  endtask

  // Lone request from an idle arbiter, with the fixed cycle-by-cycle timing
  task automatic run_single(input int idx, input logic [31:0] a,
                            input logic [31:0] b, input logic [16:0] op,
                            input logic [31:0] exp);
    @(posedge clk); #1;
    set_req(idx, a, b, op);
    req_valid[idx] = 1'b1;
    @(negedge clk);
    check("single_ready", 64'(req_ready), 64'(4'b0001 << idx));
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    @(negedge clk);
    check("single_alu_a", 64'(alu_a), 64'(a));
    check("single_alu_b", 64'(alu_b), 64'(b));
    check("single_alu_op", 64'(alu_op), 64'(op));
    check("single_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("single_rsp_valid", 64'(rsp_valid), 64'(4'b0001 << idx));
    check("single_rsp_data", 64'(rsp_data), 64'(exp));
    @(negedge clk);
    check("single_idle", 64'(busy), 64'd0);
  endtask

  task automatic wait_grant(input string tag, input logic [N-1:0] exp);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready != '0) break;
    end
    check(tag, 64'(req_ready), 64'(exp));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("rst_alu_b", 64'(alu_b), 64'd0);
    check("rst_alu_op", 64'(alu_op), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);

    // ---------------- single ADD and SLL
    run_single(0, 32'd7, 32'd6, 17'h00033, 32'h0000000D);
    run_single(1, 32'd5, 32'd6, 17'h000B3, 32'h00000140);

    // ---------------- all four continuously valid, from a fresh pointer
    do_reset();
    set_req(0, 32'h1234_0000, 32'h0000_5678, make_op(F7_BASE, F3_ADD_SUB, OPC_OP));
    set_req(1, 32'd100, 32'd250, make_op(F7_ALT, F3_ADD_SUB, OPC_OP));
    set_req(2, 32'hF0F0_A5A5, 32'h0FF0_FFFF, make_op(F7_BASE, F3_XOR, OPC_OP));
    set_req(3, 32'hDEAD_BEEF, 32'h00FF_FF00, make_op(F7_BASE, F3_AND, OPC_OP));
    rsp_ready = '1;
    req_valid = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      check($sformatf("rr_ready_c%0d", c), 64'(req_ready),
            (c % 3 == 0) ? 64'(4'b0001 << ((c / 3) % 4)) : 64'd0);
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(negedge clk);

    // ---------------- backpressure on requester 2
    @(posedge clk); #1;
    set_req(2, 32'h8000_0001, 32'd4, make_op(F7_ALT, F3_SRL_SRA, OPC_OP));
    req_valid = 4'b0100;
    rsp_ready = 4'b1011;
    @(negedge clk);
    check("bp_ready", 64'(req_ready), 64'(4'b0100));
    @(posedge clk); #1;
    set_req(0, 32'd9, 32'd3, make_op(F7_BASE, F3_OR, OPC_OP));
    req_valid = 4'b0001;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
      check("bp_rsp_data", 64'(rsp_data), 64'h0000_0000_F800_0000);
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = '1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_ready", 64'(req_ready), 64'(4'b0001));
    @(posedge clk); #1;
    req_valid = '0;
    repeat (5) @(negedge clk);

    // ---------------- pointer wrap and fairness
    run_single(3, 32'hFFFF_FFFF, 32'd1, make_op(F7_BASE, F3_SLT, OPC_OP), 32'd1);
    @(posedge clk); #1;
    set_req(0, 32'd40, 32'd2, make_op(F7_BASE, F3_ADD_SUB, OPC_OP));
    set_req(3, 32'd1, 32'd31, make_op(F7_BASE, F3_SLL, OPC_OP));
    req_valid = 4'b1001;
    wait_grant("wrap_first", 4'b0001);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_grant("wrap_second", 4'b1000);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    repeat (5) @(negedge clk);

    // ---------------- reset during EXEC
    @(posedge clk); #1;
    set_req(0, 32'd11, 32'd22, make_op(F7_BASE, F3_ADD_SUB, OPC_OP));
    set_req(2, 32'd3, 32'd3, make_op(F7_BASE, F3_SLTU, OPC_OP));
    req_valid = 4'b0001;
    @(negedge clk);
    check("rx_accept", 64'(req_ready), 64'(4'b0001));
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 4'b0101;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rx_busy", 64'(busy), 64'd0);
    check("rx_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rx_alu_a", 64'(alu_a), 64'd0);
    check("rx_alu_b", 64'(alu_b), 64'd0);
    check("rx_alu_op", 64'(alu_op), 64'd0);
    check("rx_rsp_data", 64'(rsp_data), 64'd0);
    check("rx_reaccept", 64'(req_ready), 64'(4'b0001));
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_grant("rx_next", 4'b0100);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    repeat (6) @(negedge clk);

    check("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
